// File: rtl/sha256_sched.sv
// SHA-256 message-schedule controller: expands one padded 512-bit block
// into W[0..63] and streams one word per round over valid/ready.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   blk_data       512-bit padded block, word i at [32i+31:32i]
//   blk_valid      block valid; blk_last marks final block of message
//   blk_ready      block slot free (IDLE)
//   w_data         schedule word W[t]
//   w_round        round index t
//   w_valid        word valid (RUN)
//   w_first/w_last t==0 / t==63
//   w_ready        compression core accepts the word
//   msg_done       one-cycle pulse after round 63 of a final block
module sha256_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk_data,
    input  logic         blk_valid,
    input  logic         blk_last,
    output logic         blk_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_round,
    output logic         w_valid,
    output logic         w_first,
    output logic         w_last,
    input  logic         w_ready,
    output logic         msg_done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [5:0]  t;
    logic [31:0] win [16];
    logic        last_q;
    logic [31:0] next_w;

    function automatic logic [31:0] rotr(input logic [31:0] x,
                                         input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // win[k] holds W[t+k]; the new tail word is W[t+16].
    assign next_w = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            t        <= 6'd0;
            last_q   <= 1'b0;
            msg_done <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                win[k] <= 32'd0;
            end
        end else begin
            msg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= blk_data[32*i +: 32];
                        end
                        last_q <= blk_last;
                        t      <= 6'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        for (int k = 0; k < 15; k++) begin
                            win[k] <= win[k+1];
                        end
                        win[15] <= next_w;
                        if (t == 6'd63) begin
                            state    <= IDLE;
                            t        <= 6'd0;
                            msg_done <= last_q;
                        end else begin
                            t <= t + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign blk_ready = (state == IDLE);
    assign w_valid   = (state == RUN);
    assign w_data    = win[0];
    assign w_round   = t;
    assign w_first   = (t == 6'd0);
    assign w_last    = (t == 6'd63);

endmodule

// File: tb/tb_sha256_sched.sv
// Testbench for sha256_sched: random and directed blocks checked every
// cycle against a whole-schedule reference model.
module tb_sha256_sched;

    logic         clk;
    logic         rst;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_round;
    logic         w_valid;
    logic         w_first;
    logic         w_last;
    logic         w_ready;
    logic         msg_done;

    sha256_sched dut (
        .clk       (clk),
        .rst       (rst),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready),
        .w_data    (w_data),
        .w_round   (w_round),
        .w_valid   (w_valid),
        .w_first   (w_first),
        .w_last    (w_last),
        .w_ready   (w_ready),
        .msg_done  (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: full 64-word schedule computed up front.
    logic [31:0] m_w [64];
    int          m_t;
    logic        m_busy;
    logic        m_done;
    logic        m_last;
    logic        m_fresh;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic void expand(input logic [511:0] d);
        for (int i = 0; i < 16; i++) m_w[i] = d[32*i +: 32];
        for (int i = 16; i < 64; i++)
            m_w[i] = s1(m_w[i-2]) + m_w[i-7] + s0(m_w[i-15]) + m_w[i-16];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_t     = 0;
            m_done  = 1'b0;
            m_last  = 1'b0;
            m_fresh = 1'b1;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (blk_valid) begin
                expand(blk_data);
                m_last  = blk_last;
                m_t     = 0;
                m_busy  = 1'b1;
                m_fresh = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (w_ready) begin
                if (m_t == 63) begin
                    m_busy = 1'b0;
                    m_done = m_last;
                    m_t    = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          ndone = 0;
    int          nfirst = 0;
    int          nlast = 0;
    logic [31:0] obs [64];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("blk_ready", 32'(blk_ready), 32'(!m_busy));
        chk("w_valid", 32'(w_valid), 32'(m_busy));
        chk("msg_done", 32'(msg_done), 32'(m_done));
        if (m_busy) begin
            chk("w_data", w_data, m_w[m_t]);
            chk("w_round", 32'(w_round), 32'(m_t));
            chk("w_first", 32'(w_first), 32'(m_t == 0));
            chk("w_last", 32'(w_last), 32'(m_t == 63));
        end else if (m_fresh) begin
            chk("rst_w_data", w_data, 32'd0);
            chk("rst_w_round", 32'(w_round), 32'd0);
            chk("rst_w_first", 32'(w_first), 32'd1);
            chk("rst_w_last", 32'(w_last), 32'd0);
        end
        if (rst && w_valid && w_ready) begin
            obs[w_round] = w_data;
            if (w_first) nfirst++;
            if (w_last) nlast++;
        end
        if (rst && blk_valid && blk_ready) acc_cyc = cyc + 1;
        if (msg_done) begin
            ndone++;
            done_cyc = cyc;
        end
    end

    int ready_mode = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (ready_mode == 1) w_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_block(input logic [511:0] d, input logic last);
        bit got = 0;
        blk_data  = d;
        blk_last  = last;
        blk_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (blk_ready) got = 1;
            step();
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n0 = ndone;
        for (int i = 0; i < budget && ndone == n0; i++) step();
        chk("done_count", 32'(ndone - n0), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && m_busy; i++) step();
        chk("idle_timeout", 32'(m_busy), 32'd0);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    logic [511:0] abc;
    logic [511:0] blk_b;
    int           acc1;
    int           n0;

    initial begin
        abc            = '0;
        abc[31:0]      = 32'h61626380;
        abc[511:480]   = 32'h00000018;
        rst       = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_last  = 1'b0;
        w_ready   = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();

        // abc block, w_ready held high
        nfirst = 0;
        nlast  = 0;
        n0     = ndone;
        send_block(abc, 1'b1);
        blk_valid = 1'b0;
        chk("model_w16", m_w[16], 32'h61626380);
        chk("model_w17", m_w[17], 32'h000F0000);
        wait_done(200);
        chk("abc_w0", obs[0], 32'h61626380);
        chk("abc_w15", obs[15], 32'h00000018);
        chk("abc_w16", obs[16], 32'h61626380);
        chk("abc_w17", obs[17], 32'h000F0000);
        chk("abc_nfirst", 32'(nfirst), 32'd1);
        chk("abc_nlast", 32'(nlast), 32'd1);
        chk("abc_latency", 32'(done_cyc - acc_cyc), 32'd64);
        repeat (3) step();
        chk("abc_single_done", 32'(ndone - n0), 32'd1);

        // abc block with w_ready toggling every cycle
        ready_mode = 2;
        send_block(abc, 1'b1);
        blk_valid = 1'b0;
        n0 = ndone;
        for (int i = 0; i < 300 && ndone == n0; i++) begin
            w_ready = (i % 2) == 1;
            step();
        end
        chk("tog_done", 32'(ndone - n0), 32'd1);
        chk("tog_latency", 32'(done_cyc - acc_cyc), 32'd128);
        chk("tog_w17", obs[17], 32'h000F0000);
        w_ready    = 1'b1;
        ready_mode = 0;
        step();

        // back-to-back with blk_valid held and data churning in RUN
        n0 = ndone;
        send_block(rand_block(), 1'b0);
        acc1 = acc_cyc;
        blk_last = 1'b1;
        for (int i = 0; i < 63; i++) begin
            blk_data = rand_block();
            step();
        end
        blk_b = rand_block();
        blk_data = blk_b;
        step();
        step();
        blk_valid = 1'b0;
        chk("b2b_accept_gap", 32'(acc_cyc - acc1), 32'd65);
        chk("b2b_no_done_first", 32'(ndone - n0), 32'd0);
        wait_done(200);
        chk("b2b_w0", obs[0], blk_b[31:0]);
        chk("b2b_w63", obs[63], m_w[63]);

        // asynchronous reset at t=30
        n0 = ndone;
        send_block(rand_block(), 1'b1);
        blk_valid = 1'b0;
        repeat (30) step();
        rst = 1'b0;
        #1;
        chk("arst_w_valid", 32'(w_valid), 32'd0);
        chk("arst_blk_ready", 32'(blk_ready), 32'd1);
        chk("arst_w_data", w_data, 32'd0);
        chk("arst_w_round", 32'(w_round), 32'd0);
        chk("arst_w_first", 32'(w_first), 32'd1);
        repeat (3) step();
        rst = 1'b1;
        repeat (70) step();
        chk("arst_no_done", 32'(ndone - n0), 32'd0);
        nfirst = 0;
        nlast  = 0;
        send_block(abc, 1'b1);
        blk_valid = 1'b0;
        wait_done(200);
        chk("arst_abc_w17", obs[17], 32'h000F0000);
        chk("arst_nfirst", 32'(nfirst), 32'd1);
        chk("arst_nlast", 32'(nlast), 32'd1);

        // all-ones block exercises carry discard
        send_block({512{1'b1}}, 1'b1);
        blk_valid = 1'b0;
        chk("model_ones_w16", m_w[16], 32'h203FFFFC);
        wait_done(200);
        chk("ones_w16", obs[16], 32'h203FFFFC);

        // random blocks with random backpressure
        ready_mode = 1;
        for (int b = 0; b < 8; b++) begin
            repeat ($urandom_range(0, 3)) step();
            send_block(rand_block(), 1'($urandom_range(0, 1)));
            blk_valid = 1'b0;
            wait_idle(500);
        end
        ready_mode = 0;
        w_ready    = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
